// File: rtl/siso_pkg.sv
// siso_pkg: shared elaboration helpers for the siso delay line
// Contents:
//   depth_ok - legality check for the DEPTH parameter
package siso_pkg;

    function automatic bit depth_ok(input int depth);
        return depth >= 1;
    endfunction

endpackage

// File: rtl/siso_dff.sv
// siso_dff: one stage of the siso delay line, 1-bit flop with async active-high reset
// Ports:
//   i_clk - clock, rising edge
//   i_rst - asynchronous active-high reset, loads RESET_VALUE
//   i_d   - data in
//   o_q   - registered data out
module siso_dff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    always_ff @(posedge i_clk or posedge i_rst)
        o_q <= i_rst ? RESET_VALUE : i_d;

endmodule

// File: rtl/siso.sv
// siso: serial-in/serial-out shift register, DEPTH-cycle delay line for a bit stream
// Ports:
//   i_clk        - clock, all shifting on rising edge
//   i_rst        - asynchronous active-high reset, every stage loads RESET_VALUE
//   i_serial_in  - serial input, sampled every rising edge
//   o_serial_out - serial output, driven straight from the last stage flop
module siso
    import siso_pkg::*;
#(
    parameter int   DEPTH       = 4,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_serial_in,
    output logic o_serial_out
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("siso: DEPTH must be >= 1");
    end

    logic [DEPTH-1:0] sr;

    // Stage 0 takes the input; every other stage takes its predecessor. Split per
    // stage so DEPTH=1 never builds a zero-width slice.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic d;
        if (g == 0) begin : g_first
            assign d = i_serial_in;
        end else begin : g_next
            assign d = sr[g-1];
        end
        siso_dff #(.RESET_VALUE(RESET_VALUE)) u_dff (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_d   (d),
            .o_q   (sr[g])
        );
    end

    assign o_serial_out = sr[DEPTH-1];

endmodule

// File: tb/tb_siso.sv
// tb_siso: scoreboard bench for siso at DEPTH=4 and DEPTH=1
module tb_siso;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b1;
    logic out4, out1;
    int   checks = 0;
    int   failures = 0;

    siso #(.DEPTH(4), .RESET_VALUE(1'b0)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_serial_in(din), .o_serial_out(out4)
    );
    siso #(.DEPTH(1), .RESET_VALUE(1'b0)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_serial_in(din), .o_serial_out(out1)
    );

    always #5 clk = ~clk;

    // Reference: every bit sampled since reset, newest at the back. The output after
    // an edge is the bit sampled D edges ago, or the reset value while the line fills.
    bit hist[$];
    bit [1:0] exp_q[$];

    function automatic bit delayed(input int d);
        return hist.size() >= d ? hist[hist.size()-d] : 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            exp_q.delete();
        end else begin
            hist.push_back(din);
            if (hist.size() > 8) void'(hist.pop_front());
            exp_q.push_back({delayed(4), delayed(1)});
        end
    end

    task automatic check(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    // Monitor: output is valid every cycle; compare on the falling edge.
    always @(negedge clk) begin
        bit [1:0] e;
        if (rst || exp_q.size() == 0) begin
            check("out4_reset", out4, 1'b0);
            check("out1_reset", out1, 1'b0);
        end else begin
            e = exp_q.pop_front();
            check("out4", out4, e[1]);
            check("out1", out1, e[0]);
        end
    end

    task automatic drive(input logic v);
        din = v;
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        @(posedge clk);
        #2;
        check("no_shift_in_reset", out4, 1'b0);
        rst = 1'b0;
        foreach (pat[i]) drive(pat[i]);
        for (int i = 0; i < 5; i++) drive(1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1);
        for (int i = 0; i < 12; i++) drive(i[0] ? 1'b0 : 1'b1);
        for (int i = 0; i < 40; i++) drive(1'($urandom_range(0, 1)));
        for (int i = 0; i < 6; i++) drive(1'b1);
        check("pre_reset_high", out4, 1'b1);
        rst = 1'b1;
        #1;
        check("async_reset_out4", out4, 1'b0);
        check("async_reset_out1", out1, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1);
        check("refill_still_zero", out4, 1'b0);
        drive(1'b1);
        check("refill_done", out4, 1'b1);
        for (int i = 0; i < 30; i++) drive(1'($urandom_range(0, 1)));
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
